// File: rtl/vram_write_sched.sv
// VRAM write-port scheduler: merges synchronised host write strobes with a
// screen-fill engine. A host write always wins, and the displaced fill address is retried.
module vram_write_sched #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int FILL_END = 8191
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostData,
    input  logic              nHostWr,
    input  logic              fillStart,
    input  logic [DATA_W-1:0] fillData,
    output logic              fillBusy,
    output logic              fillDone,
    output logic              vramWr,
    output logic [ADDR_W-1:0] vramWrAddr,
    output logic [DATA_W-1:0] vramWrData
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FILL_END);

    logic              r_wrSync0;
    logic              r_wrSync1;
    logic              r_wrPrev;
    logic              r_hostPend;
    logic [ADDR_W-1:0] r_capAddr;
    logic [DATA_W-1:0] r_capData;
    state_t            r_state;
    logic [ADDR_W-1:0] r_fillAddr;
    logic [DATA_W-1:0] r_fillReg;
    logic              r_fillBusy;
    logic              r_fillDone;
    logic              r_vramWr;
    logic [ADDR_W-1:0] r_vramWrAddr;
    logic [DATA_W-1:0] r_vramWrData;
    logic              w_rise;

    // Two-flop synchroniser plus an edge detector on the host strobe.
    // These flops reset to 1 so that leaving reset never looks like a strobe release.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wrSync0 <= 1'b1;
            r_wrSync1 <= 1'b1;
            r_wrPrev  <= 1'b1;
        end else begin
            r_wrSync0 <= nHostWr;
            r_wrSync1 <= r_wrSync0;
            r_wrPrev  <= r_wrSync1;
        end
    end

    assign w_rise = r_wrSync1 & ~r_wrPrev;

    // Host address/data are sampled while the synchronised strobe is low.
    // The host keeps them stable, so the last sample taken before the rise is clean.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_capAddr <= '0;
            r_capData <= '0;
        end else if (!r_wrSync1) begin
            r_capAddr <= hostAddr;
            r_capData <= hostData;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_hostPend <= 1'b0;
        end else begin
            r_hostPend <= w_rise;
        end
    end

    // Write-port arbiter and fill FSM. The fill address advances only after it
    // has actually been written, so a host write delays the fill but never loses an address.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= IDLE;
            r_fillAddr   <= '0;
            r_fillReg    <= '0;
            r_fillBusy   <= 1'b0;
            r_fillDone   <= 1'b0;
            r_vramWr     <= 1'b0;
            r_vramWrAddr <= '0;
            r_vramWrData <= '0;
        end else begin
            r_vramWr   <= 1'b0;
            r_fillDone <= 1'b0;

            if (r_hostPend) begin
                r_vramWr     <= 1'b1;
                r_vramWrAddr <= r_capAddr;
                r_vramWrData <= r_capData;
            end

            case (r_state)
                IDLE: begin
                    r_fillBusy <= 1'b0;
                    if (fillStart) begin
                        r_state    <= FILL;
                        r_fillAddr <= '0;
                        r_fillReg  <= fillData;
                        r_fillBusy <= 1'b1;
                    end
                end
                FILL: begin
                    if (!r_hostPend) begin
                        r_vramWr     <= 1'b1;
                        r_vramWrAddr <= r_fillAddr;
                        r_vramWrData <= r_fillReg;
                        if (r_fillAddr == LAST_ADDR) begin
                            r_fillDone <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_fillAddr <= r_fillAddr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fillBusy   = r_fillBusy;
    assign fillDone   = r_fillDone;
    assign vramWr     = r_vramWr;
    assign vramWrAddr = r_vramWrAddr;
    assign vramWrData = r_vramWrData;

endmodule

// File: tb/tb_vram_write_sched.sv
// Self-checking bench for vram_write_sched: a monitor queues every VRAM write,
// and each test task pops these writes against the writes it expects, in order.
module tb_vram_write_sched;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 8;
    localparam int FILL_END = 15;

    logic              clk = 1'b0;
    logic              nrst;
    logic [ADDR_W-1:0] hostAddr;
    logic [DATA_W-1:0] hostData;
    logic              nHostWr;
    logic              fillStart;
    logic [DATA_W-1:0] fillData;
    logic              fillBusy;
    logic              fillDone;
    logic              vramWr;
    logic [ADDR_W-1:0] vramWrAddr;
    logic [DATA_W-1:0] vramWrData;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
        logic              done;
        logic              busy;
    } obs_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    obs_t obsQ[$];
    exp_t expQ[$];
    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatched = 0;

    vram_write_sched #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .FILL_END(FILL_END)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .hostAddr  (hostAddr),
        .hostData  (hostData),
        .nHostWr   (nHostWr),
        .fillStart (fillStart),
        .fillData  (fillData),
        .fillBusy  (fillBusy),
        .fillDone  (fillDone),
        .vramWr    (vramWr),
        .vramWrAddr(vramWrAddr),
        .vramWrData(vramWrData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        obs_t o;
        if (vramWr === 1'b1) begin
            o.addr = vramWrAddr;
            o.data = vramWrData;
            o.cyc  = cyc;
            o.done = fillDone;
            o.busy = fillBusy;
            obsQ.push_back(o);
        end
    end

    function automatic exp_t mkExp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic waitPulses(input int n, input int maxCyc);
        int k = 0;
        while (obsQ.size() < n && k < maxCyc) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        nrst      = 1'b0;
        nHostWr   = 1'b1;
        fillStart = 1'b0;
        hostAddr  = '0;
        hostData  = '0;
        fillData  = '0;
        #12;
        nCompared++;
        if (vramWr !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_vramWr: got %b expected 0", vramWr);
        end
        nCompared++;
        if (vramWrAddr !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_addr: got %h expected 0", vramWrAddr);
        end
        nCompared++;
        if (vramWrData !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_data: got %h expected 0", vramWrData);
        end
        nCompared++;
        if (fillBusy !== 1'b0 || fillDone !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_fill: got busy=%b done=%b expected 0/0", fillBusy, fillDone);
        end
        @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        nCompared++;
        if (obsQ.size() !== 0) begin
            nMismatched++;
            $display("[TB] FAIL reset_idle_writes: got %0d expected 0", obsQ.size());
        end
        obsQ.delete();
    endtask

    task automatic test_host_write();
        int   rel;
        exp_t e;
        obs_t o;
        @(negedge clk);
        expQ.push_back(mkExp(13'h0123, 8'hA5));
        hostAddr = 13'h0123;
        hostData = 8'hA5;
        nHostWr  = 1'b0;
        repeat (4) @(negedge clk);
        nHostWr = 1'b1;
        rel = cyc;
        waitPulses(1, 20);
        nCompared++;
        if (obsQ.size() !== 1) begin
            nMismatched++;
            $display("[TB] FAIL host_count: got %0d expected 1", obsQ.size());
        end
        if (obsQ.size() > 0) begin
            nCompared++;
            if (obsQ[0].cyc !== rel + 4) begin
                nMismatched++;
                $display("[TB] FAIL host_latency: got cycle %0d expected %0d", obsQ[0].cyc, rel + 4);
            end
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nCompared++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                nMismatched++;
                $display("[TB] FAIL host_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_fill();
        int   k;
        int   prevCyc;
        int   n;
        exp_t e;
        obs_t o;
        @(negedge clk);
        fillData  = 8'h20;
        fillStart = 1'b1;
        @(negedge clk);
        fillStart = 1'b0;
        for (int i = 0; i <= FILL_END; i++) expQ.push_back(mkExp(ADDR_W'(i), 8'h20));
        nCompared++;
        if (fillBusy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL fill_busy_start: got %b expected 1", fillBusy);
        end
        k = 0;
        while (fillDone !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        nCompared++;
        if (k >= 60) begin
            nMismatched++;
            $display("[TB] FAIL fill_done_timeout: got no fillDone within %0d cycles expected one", k);
        end
        nCompared++;
        if (vramWrAddr !== ADDR_W'(FILL_END) || fillBusy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL fill_done_addr: got addr=%h busy=%b expected %h/1", vramWrAddr, fillBusy, FILL_END);
        end
        @(negedge clk);
        nCompared++;
        if (fillBusy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL fill_busy_end: got %b expected 0", fillBusy);
        end
        waitPulses(FILL_END + 1, 20);
        nCompared++;
        if (obsQ.size() !== FILL_END + 1) begin
            nMismatched++;
            $display("[TB] FAIL fill_count: got %0d expected %0d", obsQ.size(), FILL_END + 1);
        end
        n = 0;
        prevCyc = 0;
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nCompared++;
            if (o.addr !== e.addr || o.data !== e.data || o.done !== (n == FILL_END) ||
                (n > 0 && o.cyc !== prevCyc + 1)) begin
                nMismatched++;
                $display("[TB] FAIL fill_write: got %h/%h done=%b cyc=%0d expected %h/%h done=%b cyc=%0d",
                         o.addr, o.data, o.done, o.cyc, e.addr, e.data, (n == FILL_END), prevCyc + 1);
            end
            prevCyc = o.cyc;
            n++;
        end
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_host_during_fill();
        exp_t e;
        obs_t o;
        for (int i = 0; i < 5; i++) expQ.push_back(mkExp(ADDR_W'(i), 8'h20));
        expQ.push_back(mkExp(13'h0040, 8'h7E));
        for (int i = 5; i <= FILL_END; i++) expQ.push_back(mkExp(ADDR_W'(i), 8'h20));
        @(negedge clk);
        hostAddr = 13'h0040;
        hostData = 8'h7E;
        nHostWr  = 1'b0;
        @(negedge clk);
        fillData  = 8'h20;
        fillStart = 1'b1;
        @(negedge clk);
        fillStart = 1'b0;
        repeat (2) @(negedge clk);
        nHostWr = 1'b1;
        waitPulses(FILL_END + 2, 80);
        nCompared++;
        if (obsQ.size() !== FILL_END + 2) begin
            nMismatched++;
            $display("[TB] FAIL mix_count: got %0d expected %0d", obsQ.size(), FILL_END + 2);
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nCompared++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                nMismatched++;
                $display("[TB] FAIL mix_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_fill_restart();
        int   k;
        exp_t e;
        obs_t o;
        @(negedge clk);
        fillData  = 8'h20;
        fillStart = 1'b1;
        @(negedge clk);
        fillStart = 1'b0;
        repeat (2) @(negedge clk);
        fillData  = 8'hFF;
        fillStart = 1'b1;
        @(negedge clk);
        fillStart = 1'b0;
        k = 0;
        while (!(vramWr === 1'b1 && vramWrAddr === ADDR_W'(6)) && k < 40) begin
            @(negedge clk);
            k++;
        end
        nrst = 1'b0;
        #1;
        nCompared++;
        if (vramWr !== 1'b0 || vramWrAddr !== '0 || vramWrData !== '0 ||
            fillBusy !== 1'b0 || fillDone !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midfill_reset: got wr=%b addr=%h data=%h busy=%b done=%b expected all 0",
                     vramWr, vramWrAddr, vramWrData, fillBusy, fillDone);
        end
        for (int i = 0; i < 7; i++) expQ.push_back(mkExp(ADDR_W'(i), 8'h20));
        nCompared++;
        if (obsQ.size() !== 7) begin
            nMismatched++;
            $display("[TB] FAIL ignore_start_count: got %0d expected 7", obsQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nCompared++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                nMismatched++;
                $display("[TB] FAIL ignore_start: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
        expQ.delete();
        obsQ.delete();
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        fillData  = 8'h33;
        fillStart = 1'b1;
        @(negedge clk);
        fillStart = 1'b0;
        for (int i = 0; i <= FILL_END; i++) expQ.push_back(mkExp(ADDR_W'(i), 8'h33));
        waitPulses(FILL_END + 1, 60);
        nCompared++;
        if (obsQ.size() !== FILL_END + 1) begin
            nMismatched++;
            $display("[TB] FAIL restart_count: got %0d expected %0d", obsQ.size(), FILL_END + 1);
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nCompared++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                nMismatched++;
                $display("[TB] FAIL restart_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_back_to_back();
        int   rel1;
        int   rel2;
        exp_t e;
        obs_t o;
        expQ.push_back(mkExp(13'h1000, 8'h11));
        expQ.push_back(mkExp(13'h1001, 8'h22));
        @(negedge clk);
        hostAddr = 13'h1000;
        hostData = 8'h11;
        nHostWr  = 1'b0;
        repeat (2) @(negedge clk);
        nHostWr = 1'b1;
        rel1 = cyc;
        repeat (2) @(negedge clk);
        hostAddr = 13'h1001;
        hostData = 8'h22;
        nHostWr  = 1'b0;
        repeat (2) @(negedge clk);
        nHostWr = 1'b1;
        rel2 = cyc;
        repeat (2) @(negedge clk);
        waitPulses(2, 20);
        nCompared++;
        if (obsQ.size() !== 2) begin
            nMismatched++;
            $display("[TB] FAIL b2b_count: got %0d expected 2", obsQ.size());
        end
        if (obsQ.size() == 2) begin
            nCompared++;
            if (obsQ[0].cyc !== rel1 + 4 || obsQ[1].cyc !== rel2 + 4) begin
                nMismatched++;
                $display("[TB] FAIL b2b_timing: got cycles %0d,%0d expected %0d,%0d",
                         obsQ[0].cyc, obsQ[1].cyc, rel1 + 4, rel2 + 4);
            end
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nCompared++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                nMismatched++;
                $display("[TB] FAIL b2b_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
            end
        end
        expQ.delete();
        obsQ.delete();
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_fill();
        test_host_during_fill();
        test_fill_restart();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
